mem_port_arbiter: RTL

- Shares the single-port processor memory (4K x 32) between two requesters.
  - CPU port: instruction fetch and operand read/write sequencing.
  - DBG port: program loader and debug.
- Arbitration is round-robin, with a lock so that a requester can run an atomic sequence of accesses. The ADD, MUL and SHF read-modify-write sequences use this lock.
- Sits between the processor core and the memory macro. Memory has registered command inputs and 1-cycle read data.

---
 rtl/mem_port_arbiter_if.sv | 75 +++++++
 rtl/mem_port_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Bundles the signals of the shared memory port arbiter.
//               The signals are the two requester ports (CPU and DBG) and the
//               command/read-data bus to the single-port memory macro.
//               Modports:
//                 slave  - the arbiter view: requests and read data in,
//                          grants, read valids, memory command and lock_err out.
//                 master - the environment view: core, debug unit and memory
//                          macro together.
//               Requester signals (x = cpu | dbg):
//                 x_req, x_lock, x_we, x_addr[ADDR_W], x_wdata[DATA_W]  (to arbiter)
//                 x_gnt, x_rvalid, x_rdata[DATA_W]                       (from arbiter)
//               Memory signals:
//                 mem_en, mem_we, mem_addr, mem_wdata (from arbiter), mem_rdata (to arbiter)
//               Status:
//                 lock_err (from arbiter)
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
);
    // CPU requester
    logic              cpu_req;
    logic              cpu_lock;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    // DBG requester
    logic              dbg_req;
    logic              dbg_lock;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;

    // Memory macro
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Status
    logic              lock_err;

    modport slave (
        input  cpu_req, cpu_lock, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dbg_req, dbg_lock, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output lock_err
    );

    modport master (
        output cpu_req, cpu_lock, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dbg_req, dbg_lock, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  lock_err
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port memory (registered command inputs,
//               1-cycle read data) between a CPU requester and a DBG
//               requester. Round-robin arbitration with a per-requester lock
//               for atomic read-modify-write sequences; a lock is forcibly
//               released after MAX_HOLD cycles of ownership and the sticky
//               lock_err flag is raised.
// Ports       : clk   - system clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - mem_port_arbiter_if.slave (requester ports, memory
//                       command/read-data bus, lock_err)
// Parameters  : DATA_W   - data width (default 32)
//               ADDR_W   - address width (default 12)
//               MAX_HOLD - max consecutive owned cycles under lock (2..255)
// Options     : ARB_DBG_PRIO_EN - when defined, IDLE ties go to DBG with
//               strict priority instead of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 12,
    parameter int MAX_HOLD = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CPU_OWN = 2'd1,
        S_DBG_OWN = 2'd2
    } state_t;

    localparam logic       OWNER_CPU   = 1'b0;
    localparam logic       OWNER_DBG   = 1'b1;
    localparam logic [7:0] C_HOLD_LAST = 8'(MAX_HOLD - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t            state_q,    state_d;
    logic              rr_last_q,  rr_last_d;
    logic [7:0]        hold_cnt_q, hold_cnt_d;
    logic              lock_err_q, lock_err_d;

    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    // Read tag pipeline: stage 1 runs alongside the memory command,
    // stage 2 lines up with the memory read data.
    logic              rd_v1_q;
    logic              rd_own1_q;
    logic              cpu_rvalid_q;
    logic              dbg_rvalid_q;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic              w_cpu_gnt;
    logic              w_dbg_gnt;
    logic              w_acc_cpu;
    logic              w_acc_dbg;
    logic              w_acc;
    logic              w_sel_lock;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_owned;
    logic              w_timeout;

    // Grants depend only on the requests and the registered state, so a
    // requester sees its grant in the same cycle it asks.
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_dbg_gnt = 1'b0;
        case (state_q)
            S_CPU_OWN: w_cpu_gnt = bus.cpu_req;
            S_DBG_OWN: w_dbg_gnt = bus.dbg_req;
            default: begin
`ifdef ARB_DBG_PRIO_EN
                w_dbg_gnt = bus.dbg_req;
                w_cpu_gnt = bus.cpu_req & ~bus.dbg_req;
`else
                if (bus.cpu_req && bus.dbg_req) begin
                    // Tie: the requester that was not served last wins.
                    w_cpu_gnt = (rr_last_q == OWNER_DBG);
                    w_dbg_gnt = (rr_last_q == OWNER_CPU);
                end else begin
                    w_cpu_gnt = bus.cpu_req;
                    w_dbg_gnt = bus.dbg_req;
                end
`endif
            end
        endcase
    end

    assign w_acc_cpu = bus.cpu_req & w_cpu_gnt;
    assign w_acc_dbg = bus.dbg_req & w_dbg_gnt;
    assign w_acc     = w_acc_cpu | w_acc_dbg;

    assign w_sel_lock  = w_acc_dbg ? bus.dbg_lock  : bus.cpu_lock;
    assign w_sel_we    = w_acc_dbg ? bus.dbg_we    : bus.cpu_we;
    assign w_sel_addr  = w_acc_dbg ? bus.dbg_addr  : bus.cpu_addr;
    assign w_sel_wdata = w_acc_dbg ? bus.dbg_wdata : bus.cpu_wdata;

    assign w_owned   = (state_q != S_IDLE);
    assign w_timeout = w_owned && (hold_cnt_q == C_HOLD_LAST);

    // Next-state for the arbitration FSM, tie pointer, hold counter and
    // the sticky error flag.
    always_comb begin
        state_d    = state_q;
        rr_last_d  = rr_last_q;
        hold_cnt_d = hold_cnt_q;
        lock_err_d = lock_err_q;

        // Ownership time runs whether or not the owner is issuing.
        if (w_owned) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
        end

        if (w_acc) begin
            rr_last_d = w_acc_dbg ? OWNER_DBG : OWNER_CPU;
        end

        if (w_timeout) begin
            // Forced release. Any accept this cycle still goes to memory,
            // but its lock request is dropped. The owner is marked as last
            // served so the other side wins the next tie.
            state_d    = S_IDLE;
            hold_cnt_d = 8'd0;
            rr_last_d  = (state_q == S_DBG_OWN) ? OWNER_DBG : OWNER_CPU;
            // An unlocked accept on this cycle is an orderly release.
            if (!(w_acc && !w_sel_lock)) begin
                lock_err_d = 1'b1;
            end
        end else if (w_acc) begin
            if (w_sel_lock) begin
                state_d = w_acc_dbg ? S_DBG_OWN : S_CPU_OWN;
                if (state_q == S_IDLE) begin
                    hold_cnt_d = 8'd0;
                end
            end else begin
                state_d    = S_IDLE;
                hold_cnt_d = 8'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // Reset also flushes the read-tag pipeline, so reads accepted before
    // reset never produce an rvalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rr_last_q    <= OWNER_DBG;
            hold_cnt_q   <= 8'd0;
            lock_err_q   <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rd_v1_q      <= 1'b0;
            rd_own1_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_last_q  <= rr_last_d;
            hold_cnt_q <= hold_cnt_d;
            lock_err_q <= lock_err_d;

            mem_en_q <= w_acc;
            mem_we_q <= w_acc & w_sel_we;
            if (w_acc) begin
                mem_addr_q  <= w_sel_addr;
                mem_wdata_q <= w_sel_wdata;
            end

            rd_v1_q      <= w_acc & ~w_sel_we;
            rd_own1_q    <= w_acc_dbg;
            cpu_rvalid_q <= rd_v1_q & ~rd_own1_q;
            dbg_rvalid_q <= rd_v1_q &  rd_own1_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.cpu_gnt    = w_cpu_gnt;
    assign bus.dbg_gnt    = w_dbg_gnt;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.dbg_rvalid = dbg_rvalid_q;
    // Read data is a straight passthrough; rvalid qualifies it.
    assign bus.cpu_rdata  = bus.mem_rdata;
    assign bus.dbg_rdata  = bus.mem_rdata;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.lock_err   = lock_err_q;

endmodule
`default_nettype wire
